// File: rtl/parc_core_reorder_buffer_pkg.sv
// Shared ROB definitions for the pv2ooo PARC core: slot geometry, bypass mux
// encodings and functional-unit codes also used by the decode/issue scoreboard.
package parc_core_reorder_buffer_pkg;

  localparam int ROB_SLOT_W  = 4;
  localparam int ROB_ENTRIES = 16;
  localparam int ROB_PREG_W  = 5;

  typedef enum logic [2:0] {
    BYP_RF  = 3'd0,
    BYP_X   = 3'd1,
    BYP_M   = 3'd2,
    BYP_W   = 3'd3,
    BYP_MUL = 3'd4,
    BYP_ROB = 3'd5
  } byp_sel_e;

  typedef enum logic [1:0] {
    FU_NONE = 2'd0,
    FU_ALU  = 2'd1,
    FU_MEM  = 2'd2,
    FU_MUL  = 2'd3
  } fu_code_e;

  typedef struct packed {
    logic                  valid;
    logic                  filled;
    logic                  wen;
    logic [ROB_PREG_W-1:0] preg;
  } rob_ctrl_t;

  // Register r0 is hardwired, so an entry targeting it never writes back.
  function automatic logic rob_entry_wen(input logic wen, input logic [ROB_PREG_W-1:0] preg);
    return wen && (preg != 5'd0);
  endfunction

endpackage

// File: rtl/parc_core_rob_ptr.sv
// Wrapping pointer register with increment enable; used for the ROB head and tail.
module parc_core_rob_ptr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  logic [W-1:0] ptr_r;

  // Pointer register; wraps by natural overflow of the W-bit value.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r <= '0;
    end else if (inc) begin
      ptr_r <= ptr_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign ptr = ptr_r;

endmodule

// File: rtl/parc_core_reorder_buffer.sv
// parc_core_reorder_buffer: in-order retirement buffer for the pv2ooo PARC pipeline.
// Build option: define PARC_ROB_BYPASS_EN to enable the two ROB-stage bypass read ports.
module parc_core_reorder_buffer
  import parc_core_reorder_buffer_pkg::*;
#(
  parameter  int NUM_ENTRIES = ROB_ENTRIES,
  parameter  int DATA_W      = 32,
  localparam int SLOT_W      = $clog2(NUM_ENTRIES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alloc_val,
  output logic                  alloc_rdy,
  input  logic [ROB_PREG_W-1:0] alloc_preg,
  input  logic                  alloc_wen,
  output logic [SLOT_W-1:0]     alloc_slot,
  input  logic                  fill_val,
  input  logic [SLOT_W-1:0]     fill_slot,
  input  logic [DATA_W-1:0]     fill_data,
  output logic                  commit_val,
  output logic                  commit_wen,
  output logic [SLOT_W-1:0]     commit_slot,
  output logic [ROB_PREG_W-1:0] commit_waddr,
  output logic [DATA_W-1:0]     commit_wdata,
  input  logic [SLOT_W-1:0]     byp0_slot,
  output logic [DATA_W-1:0]     byp0_data,
  input  logic [SLOT_W-1:0]     byp1_slot,
  output logic [DATA_W-1:0]     byp1_data
);

  localparam logic [SLOT_W:0] FULL_CNT = NUM_ENTRIES[SLOT_W:0];

  rob_ctrl_t         ctrl_r [NUM_ENTRIES];
  logic [DATA_W-1:0] data_r [NUM_ENTRIES];
  logic [SLOT_W:0]   count_r;
  logic [SLOT_W-1:0] head_s;
  logic [SLOT_W-1:0] tail_s;
  logic              alloc_rdy_s;
  logic              alloc_fire_s;
  logic              fill_fire_s;
  logic              commit_fire_s;

  // A full ROB refuses allocation even in a cycle where it retires.
  assign alloc_rdy_s   = (count_r != FULL_CNT);
  assign alloc_fire_s  = alloc_val && alloc_rdy_s;
  assign fill_fire_s   = fill_val && ctrl_r[fill_slot].valid;
  assign commit_fire_s = ctrl_r[head_s].valid && ctrl_r[head_s].filled;

  parc_core_rob_ptr #(.W(SLOT_W)) u_head_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (commit_fire_s),
    .ptr   (head_s)
  );

  parc_core_rob_ptr #(.W(SLOT_W)) u_tail_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (alloc_fire_s),
    .ptr   (tail_s)
  );

  // Entry array: allocate at tail, retire at head, capture writeback by slot.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (reset) begin
        ctrl_r[i] <= '0;
        data_r[i] <= '0;
      end else begin
        if (alloc_fire_s && (tail_s == SLOT_W'(i))) begin
          ctrl_r[i].valid  <= 1'b1;
          ctrl_r[i].filled <= 1'b0;
          ctrl_r[i].wen    <= rob_entry_wen(alloc_wen, alloc_preg);
          ctrl_r[i].preg   <= alloc_preg;
        end else if (commit_fire_s && (head_s == SLOT_W'(i))) begin
          ctrl_r[i].valid <= 1'b0;
        end else begin
          ctrl_r[i].valid <= ctrl_r[i].valid;
        end
        if (fill_fire_s && (fill_slot == SLOT_W'(i))) begin
          ctrl_r[i].filled <= 1'b1;
          data_r[i]        <= fill_data;
        end
      end
    end
  end

  // Occupancy counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= '0;
    end else begin
      case ({alloc_fire_s, commit_fire_s})
        2'b10:   count_r <= count_r + {{SLOT_W{1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{SLOT_W{1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  assign alloc_rdy  = alloc_rdy_s;
  assign alloc_slot = tail_s;

  // Retirement outputs, derived from registered state only.
  always_comb begin
    commit_val  = commit_fire_s;
    commit_slot = head_s;
    if (commit_fire_s) begin
      commit_wen   = ctrl_r[head_s].wen;
      commit_waddr = ctrl_r[head_s].preg;
      commit_wdata = data_r[head_s];
    end else begin
      commit_wen   = 1'b0;
      commit_waddr = '0;
      commit_wdata = '0;
    end
  end

`ifdef PARC_ROB_BYPASS_EN
  assign byp0_data = data_r[byp0_slot];
  assign byp1_data = data_r[byp1_slot];
`else
  logic unused_byp_s;
  assign unused_byp_s = ^{byp0_slot, byp1_slot};
  assign byp0_data    = '0;
  assign byp1_data    = '0;
`endif

endmodule

// File: tb/tb_parc_core_reorder_buffer.sv
// Directed self-checking bench for parc_core_reorder_buffer (either PARC_ROB_BYPASS_EN build).
module tb_parc_core_reorder_buffer;

  logic        clk;
  logic        reset;
  logic        alloc_val;
  logic        alloc_rdy;
  logic [4:0]  alloc_preg;
  logic        alloc_wen;
  logic [3:0]  alloc_slot;
  logic        fill_val;
  logic [3:0]  fill_slot;
  logic [31:0] fill_data;
  logic        commit_val;
  logic        commit_wen;
  logic [3:0]  commit_slot;
  logic [4:0]  commit_waddr;
  logic [31:0] commit_wdata;
  logic [3:0]  byp0_slot;
  logic [31:0] byp0_data;
  logic [3:0]  byp1_slot;
  logic [31:0] byp1_data;

  int total;
  int bad;

  parc_core_reorder_buffer dut (
    .clk          (clk),
    .reset        (reset),
    .alloc_val    (alloc_val),
    .alloc_rdy    (alloc_rdy),
    .alloc_preg   (alloc_preg),
    .alloc_wen    (alloc_wen),
    .alloc_slot   (alloc_slot),
    .fill_val     (fill_val),
    .fill_slot    (fill_slot),
    .fill_data    (fill_data),
    .commit_val   (commit_val),
    .commit_wen   (commit_wen),
    .commit_slot  (commit_slot),
    .commit_waddr (commit_waddr),
    .commit_wdata (commit_wdata),
    .byp0_slot    (byp0_slot),
    .byp0_data    (byp0_data),
    .byp1_slot    (byp1_slot),
    .byp1_data    (byp1_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_commit(input string tag, input logic [3:0] slot, input logic wen,
                            input logic [4:0] waddr, input logic [31:0] wdata);
    chk({tag, "_val"},   32'(commit_val),   32'd1);
    chk({tag, "_slot"},  32'(commit_slot),  32'(slot));
    chk({tag, "_wen"},   32'(commit_wen),   32'(wen));
    chk({tag, "_waddr"}, 32'(commit_waddr), 32'(waddr));
    chk({tag, "_wdata"}, commit_wdata,      wdata);
  endtask

  logic [31:0] byp_exp;

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1; alloc_val = 1'b0; alloc_preg = 5'd0; alloc_wen = 1'b0;
    fill_val = 1'b0; fill_slot = 4'd0; fill_data = 32'd0;
    byp0_slot = 4'd0; byp1_slot = 4'd0;
    tick(); tick();

    // Reset state
    chk("rst_alloc_rdy",  32'(alloc_rdy),   32'd1);
    chk("rst_alloc_slot", 32'(alloc_slot),  32'd0);
    chk("rst_commit_val", 32'(commit_val),  32'd0);
    chk("rst_commit_wen", 32'(commit_wen),  32'd0);
    chk("rst_commit_slot",32'(commit_slot), 32'd0);
    chk("rst_waddr",      32'(commit_waddr),32'd0);
    chk("rst_wdata",      commit_wdata,     32'd0);
    chk("rst_byp0",       byp0_data,        32'd0);
    chk("rst_byp1",       byp1_data,        32'd0);
    reset = 1'b0;

    // Two allocations, out-of-order fill, in-order commit
    alloc_val = 1'b1; alloc_preg = 5'd5; alloc_wen = 1'b1;
    chk("a0_slot", 32'(alloc_slot), 32'd0);
    tick();
    alloc_preg = 5'd7;
    chk("a1_slot", 32'(alloc_slot), 32'd1);
    tick();
    alloc_val = 1'b0;
    fill_val = 1'b1; fill_slot = 4'd1; fill_data = 32'h0000_BEEF;
    tick();
    fill_val = 1'b0;
    chk("ooo_fill_no_commit", 32'(commit_val), 32'd0);
    fill_val = 1'b1; fill_slot = 4'd0; fill_data = 32'h0000_1234;
    #1;
    chk("fill_no_comb_commit", 32'(commit_val), 32'd0);
    tick();
    fill_val = 1'b0;
    chk_commit("c0", 4'd0, 1'b1, 5'd5, 32'h0000_1234);
    tick();
    chk_commit("c1", 4'd1, 1'b1, 5'd7, 32'h0000_BEEF);
    tick();
    chk("empty_commit_val", 32'(commit_val),   32'd0);
    chk("empty_wdata",      commit_wdata,      32'd0);

    // Fill to never-allocated slot 9 is ignored
    fill_val = 1'b1; fill_slot = 4'd9; fill_data = 32'h0000_DEAD;
    tick();
    fill_val = 1'b0;
    tick();
    chk("bogus_fill_commit", 32'(commit_val), 32'd0);
    chk("bogus_fill_tail",   32'(alloc_slot), 32'd2);
    chk("bogus_fill_rdy",    32'(alloc_rdy),  32'd1);

    // preg 0 never writes back
    alloc_val = 1'b1; alloc_preg = 5'd0; alloc_wen = 1'b1;
    tick();
    alloc_val = 1'b0;
    fill_val = 1'b1; fill_slot = 4'd2; fill_data = 32'h0000_0055;
    tick();
    fill_val = 1'b0;
    chk_commit("c_r0", 4'd2, 1'b0, 5'd0, 32'h0000_0055);
    tick();

    // Bypass read of slot 3, no same-cycle forwarding
    alloc_val = 1'b1; alloc_preg = 5'd9; alloc_wen = 1'b1;
    tick();
    alloc_val = 1'b0;
    fill_val = 1'b1; fill_slot = 4'd3; fill_data = 32'h0000_CAFE;
    byp0_slot = 4'd3; byp1_slot = 4'd3;
    #1;
    chk("byp0_no_fwd", byp0_data, 32'd0);
    tick();
    fill_val = 1'b0;
`ifdef PARC_ROB_BYPASS_EN
    byp_exp = 32'h0000_CAFE;
`else
    byp_exp = 32'd0;
`endif
    chk("byp0_after_fill", byp0_data, byp_exp);
    chk("byp1_after_fill", byp1_data, byp_exp);
    chk_commit("c3", 4'd3, 1'b1, 5'd9, 32'h0000_CAFE);
    tick();

    // Full ROB from a clean start
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      alloc_val = 1'b1; alloc_preg = 5'(i + 1); alloc_wen = 1'b1;
      chk("fill_up_rdy",  32'(alloc_rdy),  32'd1);
      chk("fill_up_slot", 32'(alloc_slot), 32'(i));
      tick();
    end
    chk("full_rdy",  32'(alloc_rdy),  32'd0);
    chk("full_tail", 32'(alloc_slot), 32'd0);
    tick();
    chk("a17_ignored_tail", 32'(alloc_slot), 32'd0);
    chk("a17_ignored_rdy",  32'(alloc_rdy),  32'd0);
    fill_val = 1'b1; fill_slot = 4'd0; fill_data = 32'h0000_0100;
    tick();
    fill_val = 1'b0;
    chk("full_commit_rdy", 32'(alloc_rdy), 32'd0);
    chk_commit("c_full", 4'd0, 1'b1, 5'd1, 32'h0000_0100);
    tick();
    chk("post_commit_rdy",  32'(alloc_rdy),  32'd1);
    chk("post_commit_tail", 32'(alloc_slot), 32'd0);
    chk("post_commit_val",  32'(commit_val), 32'd0);
    chk("post_commit_head", 32'(commit_slot),32'd1);
    alloc_preg = 5'd20;
    tick();
    alloc_val = 1'b0;
    chk("wrap_tail", 32'(alloc_slot), 32'd1);
    chk("wrap_rdy",  32'(alloc_rdy),  32'd0);

    // Reset with 5 entries in flight, head ready to retire
    reset = 1'b1;
    tick();
    reset = 1'b0;
    alloc_val = 1'b1; alloc_preg = 5'd3; alloc_wen = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    alloc_val = 1'b0;
    fill_val = 1'b1; fill_slot = 4'd0; fill_data = 32'h0000_0011;
    tick();
    fill_val = 1'b0;
    chk("pre_rst_commit_val", 32'(commit_val), 32'd1);
    chk("pre_rst_tail",       32'(alloc_slot), 32'd5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_tail",       32'(alloc_slot),  32'd0);
    chk("mid_rst_rdy",        32'(alloc_rdy),   32'd1);
    chk("mid_rst_commit_val", 32'(commit_val),  32'd0);
    chk("mid_rst_wdata",      commit_wdata,     32'd0);
    fill_val = 1'b1; fill_slot = 4'd2; fill_data = 32'h0000_0022;
    byp0_slot = 4'd2;
    tick();
    fill_val = 1'b0;
    tick();
    chk("post_rst_fill_commit", 32'(commit_val), 32'd0);
    chk("post_rst_fill_byp",    byp0_data,       32'd0);
    chk("post_rst_fill_tail",   32'(alloc_slot), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
